// File: rtl/control_unit_mc.sv
// control_unit_mc: multi-cycle control unit that fetches, decodes and sequences eight opcodes.
// Latency: MOV/ALU/JMP/NOP 3 cycles, LD/ST/LDI 4, STI 5 with zero-wait memories, +1 per wait cycle.
// Backpressure: holds in FETCH/IMM while i_Instr_Valid=0 and in MEM while i_Mem_Ready=0.
//
// Optional feature: define CU_HALT_EN to add the o_Halted port. In that build, a NOP whose
// Rx field is all ones parks the unit in HALT, and only Rst releases it.
//
// Ports:
//   Clk, Rst              rising-edge clock, synchronous active-high reset
//   i_Instruction         {op[2:0], Rx, Ry/f}, width 3+2*REG_AW; i_Instr_Valid qualifies it
//   i_Rx, Flags           jump target register value, condition flags {N,C,Z}
//   i_Mem_Ready           data memory completion
//   o_Fetch, o_Addres_Instr_Bus   instruction request and its address (PC)
//   o_Mem_Req, RW         data memory request, 1 = store
//   SelR, Sel_OP, Sel_Op_OutBus, Sel_DW   datapath selects
//   o_Imm                 latched immediate
module control_unit_mc #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int REG_AW = 3
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic [3+2*REG_AW-1:0] i_Instruction,
   input  logic                  i_Instr_Valid,
   input  logic [DATA_W-1:0]     i_Rx,
   input  logic [2:0]            Flags,
   input  logic                  i_Mem_Ready,
   output logic                  o_Fetch,
   output logic [ADDR_W-1:0]     o_Addres_Instr_Bus,
   output logic                  o_Mem_Req,
   output logic                  RW,
   output logic [2*REG_AW-1:0]   SelR,
   output logic [2:0]            Sel_OP,
   output logic [1:0]            Sel_Op_OutBus,
   output logic [2:0]            Sel_DW,
   output logic [DATA_W-1:0]     o_Imm
`ifdef CU_HALT_EN
   ,
   output logic                  o_Halted
`endif
);

   localparam int INSTR_W = 3 + 2*REG_AW;

   localparam logic [2:0] OP_LDI = 3'b000;
   localparam logic [2:0] OP_LD  = 3'b001;
   localparam logic [2:0] OP_STI = 3'b010;
   localparam logic [2:0] OP_ST  = 3'b011;
   localparam logic [2:0] OP_MOV = 3'b100;
   localparam logic [2:0] OP_ALU = 3'b101;
   localparam logic [2:0] OP_JMP = 3'b110;
   localparam logic [2:0] OP_NOP = 3'b111;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_IMM,
      S_MEM,
      S_EXEC
`ifdef CU_HALT_EN
      ,
      S_HALT
`endif
   } state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   pc;
   logic [INSTR_W-1:0]  ir;
   logic [DATA_W-1:0]   imm_q;
   logic [2:0]          op;
   logic [2:0]          f;
   logic                jmp_cond;

   assign op = ir[INSTR_W-1 -: 3];
   assign f  = ir[2:0];

`ifdef CU_HALT_EN
   logic [REG_AW-1:0] rx_field;
   assign rx_field = ir[2*REG_AW-1 -: REG_AW];
`endif

   // Jump condition from the flags seen during EXEC: Flags = {N,C,Z}.
   always_comb begin
      jmp_cond = 1'b0;
      case (f)
         3'b000:  jmp_cond = 1'b1;
         3'b001:  jmp_cond = Flags[0];
         3'b010:  jmp_cond = !Flags[0];
         3'b011:  jmp_cond = Flags[1];
         3'b100:  jmp_cond = !Flags[1];
         3'b101:  jmp_cond = Flags[2];
         3'b110:  jmp_cond = !Flags[2];
         default: jmp_cond = 1'b0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= S_FETCH;
         pc    <= '0;
         ir    <= '0;
         imm_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_FETCH && i_Instr_Valid) begin
            ir <= i_Instruction;
            pc <= pc + ADDR_W'(1);
         end
         if (state == S_IMM && i_Instr_Valid) begin
            // Immediate is the low DATA_W bits of the word, zero-extended when the word is narrower.
            imm_q <= DATA_W'(i_Instruction);
            pc    <= pc + ADDR_W'(1);
         end
         if (state == S_EXEC && op == OP_JMP && jmp_cond)
            pc <= ADDR_W'(i_Rx);
      end
   end

   always_comb begin
      state_nxt          = state;
      o_Fetch            = 1'b0;
      o_Addres_Instr_Bus = '0;
      o_Mem_Req          = 1'b0;
      RW                 = 1'b0;
      SelR               = '0;
      Sel_OP             = 3'b000;
      Sel_Op_OutBus      = 2'b00;
      Sel_DW             = 3'b000;
      o_Imm              = imm_q;
`ifdef CU_HALT_EN
      o_Halted           = 1'b0;
`endif
      case (state)
         S_FETCH: begin
            o_Fetch            = 1'b1;
            o_Addres_Instr_Bus = pc;
            if (i_Instr_Valid) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            SelR = ir[2*REG_AW-1:0];
            case (op)
               OP_LDI, OP_STI: state_nxt = S_IMM;
               OP_LD,  OP_ST:  state_nxt = S_MEM;
               default:        state_nxt = S_EXEC;
            endcase
         end
         S_IMM: begin
            SelR               = ir[2*REG_AW-1:0];
            o_Fetch            = 1'b1;
            o_Addres_Instr_Bus = pc;
            if (i_Instr_Valid) state_nxt = (op == OP_LDI) ? S_EXEC : S_MEM;
         end
         S_MEM: begin
            SelR      = ir[2*REG_AW-1:0];
            o_Mem_Req = 1'b1;
            RW        = (op == OP_STI) || (op == OP_ST);
            if (op == OP_STI)     Sel_Op_OutBus = 2'b10;
            else if (op == OP_ST) Sel_Op_OutBus = 2'b01;
            if (i_Mem_Ready) state_nxt = S_EXEC;
         end
         S_EXEC: begin
            SelR      = ir[2*REG_AW-1:0];
            state_nxt = S_FETCH;
            case (op)
               OP_LDI: Sel_DW = 3'b001;
               OP_LD:  Sel_DW = 3'b010;
               OP_MOV: Sel_DW = 3'b011;
               OP_ALU: begin
                  Sel_DW        = 3'b100;
                  Sel_OP        = f;
                  Sel_Op_OutBus = 2'b11;
               end
               default: ;
            endcase
`ifdef CU_HALT_EN
            if (op == OP_NOP && rx_field == '1) state_nxt = S_HALT;
`endif
         end
`ifdef CU_HALT_EN
         S_HALT: o_Halted = 1'b1;
`endif
         default: state_nxt = S_FETCH;
      endcase

      // While Rst is held every output is forced low, even though the state register already sits in FETCH.
      if (Rst) begin
         o_Fetch            = 1'b0;
         o_Addres_Instr_Bus = '0;
         o_Mem_Req          = 1'b0;
         RW                 = 1'b0;
         SelR               = '0;
         Sel_OP             = 3'b000;
         Sel_Op_OutBus      = 2'b00;
         Sel_DW             = 3'b000;
         o_Imm              = '0;
`ifdef CU_HALT_EN
         o_Halted           = 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_control_unit_mc.sv
// tb_control_unit_mc: self-checking bench for control_unit_mc (DATA_W=8, ADDR_W=8, REG_AW=3).
// Latency: not applicable; each instruction is driven until the next first-word fetch appears.
// Backpressure: the bench inserts planned fetch/memory wait cycles and random junk outside FETCH/IMM/MEM.
module tb_control_unit_mc;
   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic [8:0] i_Instruction = '0;
   logic       i_Instr_Valid = 1'b0;
   logic [7:0] i_Rx = '0;
   logic [2:0] Flags = '0;
   logic       i_Mem_Ready = 1'b0;
   logic       o_Fetch;
   logic [7:0] o_Addres_Instr_Bus;
   logic       o_Mem_Req;
   logic       RW;
   logic [5:0] SelR;
   logic [2:0] Sel_OP;
   logic [1:0] Sel_Op_OutBus;
   logic [2:0] Sel_DW;
   logic [7:0] o_Imm;
`ifdef CU_HALT_EN
   logic       o_Halted;
`endif

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   control_unit_mc #(.DATA_W(8), .ADDR_W(8), .REG_AW(3)) dut (
      .Clk                (Clk),
      .Rst                (Rst),
      .i_Instruction      (i_Instruction),
      .i_Instr_Valid      (i_Instr_Valid),
      .i_Rx               (i_Rx),
      .Flags              (Flags),
      .i_Mem_Ready        (i_Mem_Ready),
      .o_Fetch            (o_Fetch),
      .o_Addres_Instr_Bus (o_Addres_Instr_Bus),
      .o_Mem_Req          (o_Mem_Req),
      .RW                 (RW),
      .SelR               (SelR),
      .Sel_OP             (Sel_OP),
      .Sel_Op_OutBus      (Sel_Op_OutBus),
      .Sel_DW             (Sel_DW),
      .o_Imm              (o_Imm)
`ifdef CU_HALT_EN
      ,
      .o_Halted           (o_Halted)
`endif
   );

   // Per-instruction observation (or expectation) summary.
   typedef struct {
      int         cycles;
      logic [7:0] a0;
      logic [7:0] a1;
      logic [7:0] next_addr;
      int         dw_cnt;
      logic [2:0] dw;
      int         mreq;
      logic       rw;
      logic [1:0] bus;
      int         alu_cnt;
      logic [2:0] alu_op;
      logic [5:0] selr;
      logic [7:0] imm;
      bit         timeout;
   } res_t;

   typedef struct {
      bit         rst;
      logic [8:0] w0;
      logic [8:0] w1;
      logic [2:0] fl;
      logic [7:0] rx;
      int         fw;
      int         iw;
      int         mw;
      int         cyc;
      logic [7:0] a1;
      logic [7:0] nxt;
      logic [2:0] dw;
      int         mreq;
      logic       rw;
      logic [1:0] bus;
      logic [7:0] imm;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      i_Instr_Valid = 1'b0;
      i_Mem_Ready = 1'b0;
      tick();
      tick();
      chk("rst.ctrl", {o_Fetch, o_Mem_Req, RW, Sel_OP, Sel_Op_OutBus, Sel_DW}, 0);
      chk("rst.bus", {o_Addres_Instr_Bus, SelR}, 0);
      chk("rst.imm", o_Imm, 0);
`ifdef CU_HALT_EN
      chk("rst.halted", o_Halted, 0);
`endif
      Rst = 1'b0;
      #1;
      chk("rst.fetch", o_Fetch, 1);
      chk("rst.addr", o_Addres_Instr_Bus, 0);
   endtask

   // Drives one instruction from its first FETCH cycle until the next instruction's FETCH.
   task automatic run_instr(input logic [8:0] w0, input logic [8:0] w1, input logic [2:0] fl,
                            input logic [7:0] rx, input int fw, input int iw, input int mw,
                            output res_t r);
      int words, got, stall, mstall;
      bit done;
      logic [2:0] op;
      r = '{default: 0};
      op = w0[8:6];
      words = (op == 3'b000 || op == 3'b010) ? 2 : 1;
      got = 0; stall = fw; mstall = mw; done = 0;
      Flags = fl;
      i_Rx = rx;
      while (!done) begin
         if (r.cycles >= 64) begin
            r.timeout = 1;
            break;
         end
         if (o_Fetch && got == words) begin
            done = 1;
            r.next_addr = o_Addres_Instr_Bus;
            r.imm = o_Imm;
         end else begin
            if (Sel_DW != 3'b000) begin r.dw_cnt++; r.dw = Sel_DW; end
            if (o_Mem_Req) begin r.mreq++; r.rw = RW; r.bus = Sel_Op_OutBus; end
            if (Sel_Op_OutBus == 2'b11) begin r.alu_cnt++; r.alu_op = Sel_OP; end
            if (!o_Fetch) r.selr = SelR;
            // Junk on handshakes that must be ignored outside FETCH/IMM/MEM.
            i_Instr_Valid = 1'($urandom_range(0, 1));
            i_Instruction = 9'($urandom);
            i_Mem_Ready   = 1'($urandom_range(0, 1));
            if (o_Fetch) begin
               if (stall > 0) begin
                  stall--;
                  i_Instr_Valid = 1'b0;
               end else begin
                  i_Instr_Valid = 1'b1;
                  if (got == 0) begin i_Instruction = w0; r.a0 = o_Addres_Instr_Bus; end
                  else          begin i_Instruction = w1; r.a1 = o_Addres_Instr_Bus; end
                  got++;
                  stall = iw;
               end
            end
            if (o_Mem_Req) begin
               if (mstall > 0) begin mstall--; i_Mem_Ready = 1'b0; end
               else i_Mem_Ready = 1'b1;
            end
            tick();
            r.cycles++;
         end
      end
   endtask

   function automatic bit cond_met(input logic [2:0] f, input logic [2:0] fl);
      case (f)
         3'd0: return 1'b1;
         3'd1: return fl[0];
         3'd2: return !fl[0];
         3'd3: return fl[1];
         3'd4: return !fl[1];
         3'd5: return fl[2];
         3'd6: return !fl[2];
         default: return 1'b0;
      endcase
   endfunction

   // Instruction-level reference: what one instruction should look like end to end.
   function automatic res_t model(input logic [8:0] w0, input logic [8:0] w1, input logic [2:0] fl,
                                  input logic [7:0] rx, input logic [7:0] pc, input logic [7:0] imm_in,
                                  input int fw, input int iw, input int mw);
      res_t e;
      int op;
      bit two, mem;
      e = '{default: 0};
      op  = int'(w0[8:6]);
      two = (op == 0) || (op == 2);
      mem = (op == 1) || (op == 2) || (op == 3);
      e.cycles = 3 + fw + (two ? 1 + iw : 0) + (mem ? 1 + mw : 0);
      e.a0 = pc;
      e.a1 = two ? pc + 8'd1 : 8'd0;
      case (op)
         0: begin e.dw_cnt = 1; e.dw = 3'b001; end
         1: begin e.dw_cnt = 1; e.dw = 3'b010; end
         4: begin e.dw_cnt = 1; e.dw = 3'b011; end
         5: begin e.dw_cnt = 1; e.dw = 3'b100; end
         default: ;
      endcase
      e.mreq = mem ? mw + 1 : 0;
      e.rw   = (op == 2) || (op == 3);
      e.bus  = (op == 2) ? 2'b10 : (op == 3) ? 2'b01 : 2'b00;
      e.alu_cnt = (op == 5) ? 1 : 0;
      e.alu_op  = (op == 5) ? w0[2:0] : 3'b000;
      e.selr = w0[5:0];
      e.imm  = two ? w1[7:0] : imm_in;
      if (op == 6 && cond_met(w0[2:0], fl)) e.next_addr = rx;
      else e.next_addr = pc + (two ? 8'd2 : 8'd1);
      return e;
   endfunction

   task automatic cmp(input string t, input res_t a, input res_t e);
      chk({t, ".timeout"}, a.timeout, 0);
      chk({t, ".cycles"},  a.cycles, e.cycles);
      chk({t, ".addr0"},   a.a0, e.a0);
      chk({t, ".addr1"},   a.a1, e.a1);
      chk({t, ".next"},    a.next_addr, e.next_addr);
      chk({t, ".dw_cnt"},  a.dw_cnt, e.dw_cnt);
      chk({t, ".dw"},      a.dw, e.dw);
      chk({t, ".mreq"},    a.mreq, e.mreq);
      chk({t, ".rw"},      a.rw, e.mreq > 0 ? e.rw : 1'b0);
      chk({t, ".bus"},     a.bus, e.bus);
      chk({t, ".alu_cnt"}, a.alu_cnt, e.alu_cnt);
      chk({t, ".alu_op"},  a.alu_op, e.alu_op);
      chk({t, ".selr"},    a.selr, e.selr);
      chk({t, ".imm"},     a.imm, e.imm);
   endtask

   initial begin
      vec_t vt[12];
      res_t r, e;
      logic [7:0] pc_m, imm_m;
      logic [8:0] w0, w1;

      // rst, w0, w1, fl, rx, fw, iw, mw, cycles, addr1, next, dw, mreq, rw, bus, imm
      vt[0]  = '{1, 9'b100_001_010, 9'h000, 3'b000, 8'h00, 0, 0, 0, 3, 8'h00, 8'h01, 3'b011, 0, 0, 2'b00, 8'h00};
      vt[1]  = '{1, 9'b000_011_000, 9'h05A, 3'b000, 8'h00, 0, 0, 0, 4, 8'h01, 8'h02, 3'b001, 0, 0, 2'b00, 8'h5A};
      vt[2]  = '{0, 9'b011_111_110, 9'h000, 3'b000, 8'h00, 0, 0, 3, 7, 8'h00, 8'h03, 3'b000, 4, 1, 2'b01, 8'h5A};
      vt[3]  = '{0, 9'b110_100_001, 9'h000, 3'b001, 8'hC0, 0, 0, 0, 3, 8'h00, 8'hC0, 3'b000, 0, 0, 2'b00, 8'h5A};
      vt[4]  = '{0, 9'b110_100_001, 9'h000, 3'b110, 8'hC0, 0, 0, 0, 3, 8'h00, 8'hC1, 3'b000, 0, 0, 2'b00, 8'h5A};
      vt[5]  = '{0, 9'b110_100_111, 9'h000, 3'b111, 8'hC0, 0, 0, 0, 3, 8'h00, 8'hC2, 3'b000, 0, 0, 2'b00, 8'h5A};
      vt[6]  = '{0, 9'b110_100_000, 9'h000, 3'b000, 8'hFF, 0, 0, 0, 3, 8'h00, 8'hFF, 3'b000, 0, 0, 2'b00, 8'h5A};
      vt[7]  = '{0, 9'b000_000_000, 9'h1A3, 3'b000, 8'h00, 0, 0, 0, 4, 8'h00, 8'h01, 3'b001, 0, 0, 2'b00, 8'hA3};
      vt[8]  = '{0, 9'b010_001_000, 9'h033, 3'b000, 8'h00, 0, 2, 1, 8, 8'h02, 8'h03, 3'b000, 2, 1, 2'b10, 8'h33};
      vt[9]  = '{0, 9'b001_010_011, 9'h000, 3'b000, 8'h00, 0, 0, 0, 4, 8'h00, 8'h04, 3'b010, 1, 0, 2'b00, 8'h33};
      vt[10] = '{0, 9'b101_000_110, 9'h000, 3'b000, 8'h00, 2, 0, 0, 5, 8'h00, 8'h05, 3'b100, 0, 0, 2'b00, 8'h33};
      vt[11] = '{0, 9'b111_000_000, 9'h000, 3'b000, 8'h00, 0, 0, 0, 3, 8'h00, 8'h06, 3'b000, 0, 0, 2'b00, 8'h33};

      for (int i = 0; i < 12; i++) begin
         if (vt[i].rst) do_reset();
         run_instr(vt[i].w0, vt[i].w1, vt[i].fl, vt[i].rx, vt[i].fw, vt[i].iw, vt[i].mw, r);
         chk($sformatf("vec%0d.timeout", i), r.timeout, 0);
         chk($sformatf("vec%0d.cycles", i), r.cycles, vt[i].cyc);
         chk($sformatf("vec%0d.addr1", i), r.a1, vt[i].a1);
         chk($sformatf("vec%0d.next", i), r.next_addr, vt[i].nxt);
         chk($sformatf("vec%0d.dw_cnt", i), r.dw_cnt, (vt[i].dw != 3'b000) ? 1 : 0);
         chk($sformatf("vec%0d.dw", i), r.dw, vt[i].dw);
         chk($sformatf("vec%0d.mreq", i), r.mreq, vt[i].mreq);
         chk($sformatf("vec%0d.rw", i), r.rw, vt[i].rw);
         chk($sformatf("vec%0d.bus", i), r.bus, vt[i].bus);
         chk($sformatf("vec%0d.imm", i), r.imm, vt[i].imm);
      end

      // Reset during a load's memory wait: request drops, no write strobe, fetch restarts at 0.
      do_reset();
      i_Instruction = 9'b001_000_001;
      i_Instr_Valid = 1'b1;
      tick();
      i_Instr_Valid = 1'b0;
      tick();
      chk("abort.memreq_before", o_Mem_Req, 1);
      i_Mem_Ready = 1'b0;
      tick();
      Rst = 1'b1;
      tick();
      chk("abort.memreq", o_Mem_Req, 0);
      chk("abort.fetch", o_Fetch, 0);
      chk("abort.dw", Sel_DW, 0);
      Rst = 1'b0;
      #1;
      run_instr(9'b100_001_010, 9'h000, 3'b000, 8'h00, 0, 0, 0, r);
      cmp("abort.mov", r, model(9'b100_001_010, 9'h000, 3'b000, 8'h00, 8'h00, 8'h00, 0, 0, 0));

`ifdef CU_HALT_EN
      do_reset();
      i_Instruction = 9'b111_111_000;
      i_Instr_Valid = 1'b1;
      tick();
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("halt.halted%0d", k), o_Halted, 1);
         chk($sformatf("halt.fetch%0d", k), o_Fetch, 0);
         chk($sformatf("halt.dw%0d", k), Sel_DW, 0);
         tick();
      end
      do_reset();
`endif

      // Randomized instruction stream against the instruction-level model.
      do_reset();
      pc_m = 8'h00;
      imm_m = 8'h00;
      for (int n = 0; n < 150; n++) begin
         int fw, iw, mw;
         logic [2:0] fl;
         logic [7:0] rx;
         w0 = 9'($urandom);
         w1 = 9'($urandom);
`ifdef CU_HALT_EN
         if (w0[8:6] == 3'b111 && w0[5:3] == 3'b111) w0[5:3] = 3'b000;
`endif
         fl = 3'($urandom);
         rx = 8'($urandom);
         fw = $urandom_range(0, 2);
         iw = $urandom_range(0, 2);
         mw = $urandom_range(0, 3);
         e = model(w0, w1, fl, rx, pc_m, imm_m, fw, iw, mw);
         run_instr(w0, w1, fl, rx, fw, iw, mw, r);
         cmp($sformatf("rnd%0d", n), r, e);
         pc_m  = e.next_addr;
         imm_m = e.imm;
         if (r.timeout) break;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
